// File: rtl/lanzones_pkg.sv
// Shared encodings for the lanzones memory-port arbiter: FSM states,
// requester ownership and the default response timeout.
package lanzones_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: under contention the requester that was not
// granted last wins. Purely combinational; the parent keeps last_gnt.
module rr_arb2
    import lanzones_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_gnt,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[OWN_I] && i_req[OWN_D]) begin
            o_gnt = (i_last_gnt == OWN_D) ? 2'b01 : 2'b10;
        end else if (i_req[OWN_I]) begin
            o_gnt = 2'b01;
        end else if (i_req[OWN_D]) begin
            o_gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto the single RRdy/RVld memory port,
// one transaction at a time, with a per-transaction response timeout.
module mem_port_arbiter
    import lanzones_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_strb,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            ack_err,
    output logic            bus_err,
    output logic            RRdy,
    output logic [AW-1:0]   RAddr,
    output logic            RWEn,
    output logic [DW-1:0]   RWData,
    output logic [DW/8-1:0] RWStrobe,
    input  logic            RVld,
    input  logic [DW-1:0]   RData,
    output state_t          o_dbg_state
);

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_next;
    owner_t             r_owner;
    owner_t             r_last_gnt;
    owner_t             w_gnt_owner;
    logic               r_is_store;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_err;
    logic               r_rrdy;
    logic [AW-1:0]      r_raddr;
    logic               r_rwen;
    logic [DW-1:0]      r_rwdata;
    logic [DW/8-1:0]    r_rstrb;
    logic [1:0]         w_gnt;
    logic               w_grant;
    logic               w_timeout;
    logic               w_done;
    logic [DW-1:0]      w_rdata;

    rr_arb2 u_rr_arb2 (
        .i_req      ({d_req, i_req}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt)
    );

    assign w_grant     = (r_state == ST_IDLE) && (|w_gnt);
    assign w_gnt_owner = w_gnt[OWN_D] ? OWN_D : OWN_I;
    assign w_timeout   = (r_cnt >= TO_CNT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A real response in the same cycle as the timeout wins over the error path.
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_rdata = '0;
        ack_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (RVld) begin
                    w_done  = 1'b1;
                    w_rdata = r_is_store ? '0 : RData;
                end else if (w_timeout) begin
                    w_done  = 1'b1;
                    ack_err = 1'b1;
                end
                if (w_done) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (w_done) begin
            if (r_owner == OWN_D) begin
                d_ack   = 1'b1;
                d_rdata = w_rdata;
            end else begin
                i_ack   = 1'b1;
                i_rdata = w_rdata;
            end
        end
    end

    // Bus registers are loaded on grant so they are live exactly for ISSUE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner    <= OWN_I;
            r_last_gnt <= OWN_D;
            r_is_store <= 1'b0;
            r_rrdy     <= 1'b0;
            r_raddr    <= '0;
            r_rwen     <= 1'b0;
            r_rwdata   <= '0;
            r_rstrb    <= '0;
        end else begin
            r_rrdy   <= 1'b0;
            r_raddr  <= '0;
            r_rwen   <= 1'b0;
            r_rwdata <= '0;
            r_rstrb  <= '0;
            if (w_grant) begin
                r_owner    <= w_gnt_owner;
                r_last_gnt <= w_gnt_owner;
                r_rrdy     <= 1'b1;
                if (w_gnt_owner == OWN_D) begin
                    r_is_store <= d_we;
                    r_raddr    <= d_addr;
                    r_rwen     <= d_we;
                    r_rwdata   <= d_we ? d_wdata : '0;
                    r_rstrb    <= d_we ? d_strb : '0;
                end else begin
                    r_is_store <= 1'b0;
                    r_raddr    <= i_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == ST_WAIT) && !RVld && w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign RRdy        = r_rrdy;
    assign RAddr       = r_raddr;
    assign RWEn        = r_rwen;
    assign RWData      = r_rwdata;
    assign RWStrobe    = r_rstrb;
    assign bus_err     = r_bus_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle memory model that can
// be silenced (timeout) or poked with a stray response.
module tb_mem_port_arbiter;
    import lanzones_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_ack;
    logic [DW-1:0]   i_rdata;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_strb;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;
    logic            ack_err;
    logic            bus_err;
    logic            RRdy;
    logic [AW-1:0]   RAddr;
    logic            RWEn;
    logic [DW-1:0]   RWData;
    logic [DW/8-1:0] RWStrobe;
    logic            RVld;
    logic [DW-1:0]   RData;
    state_t          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int rwen_cycles = 0;

    // clock
    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_strb(d_strb), .d_ack(d_ack), .d_rdata(d_rdata),
        .ack_err(ack_err), .bus_err(bus_err),
        .RRdy(RRdy), .RAddr(RAddr), .RWEn(RWEn), .RWData(RWData),
        .RWStrobe(RWStrobe), .RVld(RVld), .RData(RData),
        .o_dbg_state(dbg_state)
    );

    // memory model: two backed words, one-cycle response
    logic [31:0] m10 = 32'hDEADBEEF;
    logic [31:0] m20 = 32'h11223344;
    logic        mem_vld = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_dead = 1'b0;
    logic        stray = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        mem_vld   <= RRdy && !mem_dead;
        mem_rdata <= !RRdy ? 32'h0 :
                     (RAddr == 32'h10) ? m10 : (RAddr == 32'h20) ? m20 : 32'h0;
        if (RRdy && RWEn && RAddr == 32'h10) m10 <= merge(m10, RWData, RWStrobe);
        if (RRdy && RWEn && RAddr == 32'h20) m20 <= merge(m20, RWData, RWStrobe);
    end

    assign RVld  = mem_vld | stray;
    assign RData = mem_rdata;

    always @(negedge clk) if (rstn && RWEn) rwen_cycles <= rwen_cycles + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rrdy"},  64'(RRdy), 64'd0);
        check({tag, "_iack"},  64'(i_ack), 64'd0);
        check({tag, "_dack"},  64'(d_ack), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    int rr_cyc[$];
    logic [31:0] rr_addr[$];
    int n_iack, n_dack;

    initial begin
        rstn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_strb = '0;
        repeat (2) step();
        check_idle_outputs("reset");
        check("reset_buserr", 64'(bus_err), 64'd0);
        check("reset_raddr", 64'(RAddr), 64'd0);
        rstn = 1'b1;
        step();

        // fetch read
        i_req = 1'b1; i_addr = 32'h10;
        step();
        check("fetch_rrdy", 64'(RRdy), 64'd1);
        check("fetch_raddr", 64'(RAddr), 64'h10);
        check("fetch_rwen", 64'(RWEn), 64'd0);
        step();
        check("fetch_iack", 64'(i_ack), 64'd1);
        check("fetch_rdata", 64'(i_rdata), 64'hDEADBEEF);
        check("fetch_dack", 64'(d_ack), 64'd0);
        check("fetch_err", 64'(ack_err), 64'd0);
        i_req = 1'b0;
        step();
        check_idle_outputs("fetch_after");

        // store with strobe
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAABBCCDD; d_strb = 4'b0101;
        step();
        check("st_rrdy", 64'(RRdy), 64'd1);
        check("st_rwen", 64'(RWEn), 64'd1);
        check("st_wdata", 64'(RWData), 64'hAABBCCDD);
        check("st_strb", 64'(RWStrobe), 64'h5);
        step();
        check("st_dack", 64'(d_ack), 64'd1);
        check("st_rdata", 64'(d_rdata), 64'd0);
        check("st_iack", 64'(i_ack), 64'd0);
        check("st_rwen_off", 64'(RWEn), 64'd0);
        d_req = 1'b0;
        step();
        check("st_rwen_cycles", 64'(rwen_cycles), 64'd1);

        // load back merged word
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'hFFFFFFFF; d_strb = 4'hF;
        step();
        check("ld_rrdy", 64'(RRdy), 64'd1);
        check("ld_rwen", 64'(RWEn), 64'd0);
        check("ld_wdata", 64'(RWData), 64'd0);
        check("ld_strb", 64'(RWStrobe), 64'd0);
        step();
        check("ld_dack", 64'(d_ack), 64'd1);
        check("ld_rdata", 64'(d_rdata), 64'h11BB33DD);
        d_req = 1'b0;
        step();

        // simultaneous requests out of reset, both held
        rstn = 1'b0; step(); rstn = 1'b1; step();
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        n_iack = 0; n_dack = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (RRdy) begin
                rr_cyc.push_back(k);
                rr_addr.push_back(RAddr);
            end
            if (i_ack) n_iack++;
            if (d_ack) n_dack++;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_count", 64'(rr_cyc.size()), 64'd4);
        if (rr_cyc.size() == 4) begin
            check("rr_g0", 64'(rr_addr[0]), 64'h10);
            check("rr_g1", 64'(rr_addr[1]), 64'h20);
            check("rr_g2", 64'(rr_addr[2]), 64'h10);
            check("rr_g3", 64'(rr_addr[3]), 64'h20);
            check("rr_c0", 64'(rr_cyc[0]), 64'd1);
            check("rr_c1", 64'(rr_cyc[1]), 64'd4);
            check("rr_c3", 64'(rr_cyc[3]), 64'd10);
        end
        check("rr_iacks", 64'(n_iack), 64'd2);
        check("rr_dacks", 64'(n_dack), 64'd2);
        step();

        // stray RVld in IDLE
        stray = 1'b1;
        #1;
        check_idle_outputs("stray_during");
        step();
        stray = 1'b0;
        check_idle_outputs("stray_after");

        // timeout on a silent memory
        mem_dead = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        step();
        check("to_rrdy", 64'(RRdy), 64'd1);
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k == 0) check("to_state_wait", 64'(dbg_state), 64'(ST_WAIT));
            check($sformatf("to_dack_k%0d", k), 64'(d_ack), 64'(k == 4));
            if (k == 4) begin
                check("to_err", 64'(ack_err), 64'd1);
                check("to_rdata", 64'(d_rdata), 64'd0);
                d_req = 1'b0;
            end
        end
        step();
        check("to_buserr", 64'(bus_err), 64'd1);
        check("to_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        repeat (3) step();
        check("to_buserr_sticky", 64'(bus_err), 64'd1);

        // reset during WAIT
        i_req = 1'b1; i_addr = 32'h10;
        step();
        step();
        step();
        check("rst_in_wait", 64'(dbg_state), 64'(ST_WAIT));
        rstn = 1'b0;
        i_req = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_buserr", 64'(bus_err), 64'd0);
        check("rst_mid_err", 64'(ack_err), 64'd0);
        step();
        check("rst_hold_iack", 64'(i_ack), 64'd0);
        mem_dead = 1'b0;
        rstn = 1'b1;
        step();
        i_req = 1'b1; i_addr = 32'h10;
        step();
        check("post_rst_rrdy", 64'(RRdy), 64'd1);
        step();
        check("post_rst_iack", 64'(i_ack), 64'd1);
        check("post_rst_rdata", 64'(i_rdata), 64'hDEADBEEF);
        i_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
